// File: rtl/glitch_pkg.sv
// rtl/glitch_pkg.sv - shared state type and defaults for the glitch sequencer
package glitch_pkg;

  localparam int PHASE_W            = 8;
  localparam int TIMEOUT_W          = 16;
  localparam int SETTLE_CYCLES_DEF  = 8;
  localparam int TIMEOUT_CYCLES_DEF = 65535;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ARM,
    DELAY,
    GLITCH,
    FINISH
  } state_e;

endpackage

// File: rtl/phase_settle_monitor.sv
// rtl/phase_settle_monitor.sv - stability and timeout counters for the DCM phase settle stage
module phase_settle_monitor
  import glitch_pkg::*;
#(
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic phase_ready_i,
  output logic settled_o,
  output logic expired_o
);

  localparam int STAB_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0]    STAB_LAST = STAB_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [STAB_W-1:0]    stab_q, stab_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

  // A single low cycle of ready means the wrapper is still stepping, so restart the run.
  always_comb begin
    stab_d = stab_q;
    tmo_d  = tmo_q;
    if (!enable_i) begin
      stab_d = '0;
      tmo_d  = '0;
    end else begin
      if (!phase_ready_i) begin
        stab_d = '0;
      end else if (stab_q != STAB_LAST) begin
        stab_d = stab_q + STAB_W'(1);
      end
      if (tmo_q != TMO_LAST) begin
        tmo_d = tmo_q + TIMEOUT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stab_q <= '0;
      tmo_q  <= '0;
    end else begin
      stab_q <= stab_d;
      tmo_q  <= tmo_d;
    end
  end

  assign settled_o = enable_i && phase_ready_i && (stab_q == STAB_LAST);
  assign expired_o = enable_i && (tmo_q == TMO_LAST);

endmodule

// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - sequences DCM phase settle, trigger arm, delay and glitch window
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int DELAY_W        = 16,
  parameter int WIDTH_W        = 8
) (
  input  logic               clkin_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [PHASE_W-1:0] cfg_phase_i,
  input  logic [DELAY_W-1:0] cfg_delay_i,
  input  logic [WIDTH_W-1:0] cfg_width_i,
  input  logic               trigger_i,
  input  logic               phase_ready_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic               glitch_en_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o
);

  state_e             state_q;
  logic [PHASE_W-1:0] phase_q;
  logic [DELAY_W-1:0] cfg_delay_q, dcnt_q;
  logic [WIDTH_W-1:0] cfg_width_q, wcnt_q;
  logic               glitch_en_q, busy_q, done_q, timeout_q;
  logic               settled, expired;

  phase_settle_monitor #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_settle (
    .clk_i        (clkin_i),
    .rst_i        (rst_i),
    .enable_i     (state_q == SETTLE),
    .phase_ready_i(phase_ready_i),
    .settled_o    (settled),
    .expired_o    (expired)
  );

  always_ff @(posedge clkin_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      cfg_delay_q <= '0;
      cfg_width_q <= '0;
      dcnt_q      <= '0;
      wcnt_q      <= '0;
      glitch_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            phase_q     <= cfg_phase_i;
            cfg_delay_q <= cfg_delay_i;
            cfg_width_q <= cfg_width_i;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SETTLE;
          end
        end
        SETTLE: begin
          if (settled) begin
            state_q <= ARM;
          end else if (expired) begin
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= FINISH;
          end
        end
        ARM: begin
          if (trigger_i) begin
            dcnt_q  <= cfg_delay_q;
            wcnt_q  <= cfg_width_q;
            state_q <= (cfg_delay_q == '0) ? GLITCH : DELAY;
          end
        end
        DELAY: begin
          if (dcnt_q == DELAY_W'(1)) begin
            state_q <= GLITCH;
          end else begin
            dcnt_q <= dcnt_q - DELAY_W'(1);
          end
        end
        // wcnt_q holds the glitch cycles still owed; zero width exits without asserting.
        GLITCH: begin
          if (wcnt_q == '0) begin
            glitch_en_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= FINISH;
          end else begin
            glitch_en_q <= 1'b1;
            wcnt_q      <= wcnt_q - WIDTH_W'(1);
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign phase_o     = phase_q;
  assign glitch_en_o = glitch_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb/tb_glitch_sequencer.sv - schedule-based model plus directed vectors for glitch_sequencer
module tb_glitch_sequencer;

  localparam int SET = 8;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        trigger = 1'b0;
  logic        phase_ready = 1'b1;
  logic [7:0]  cfg_phase = '0;
  logic [15:0] cfg_delay = '0;
  logic [7:0]  cfg_width = '0;
  logic [7:0]  phase;
  logic        glitch_en, busy, done, timeout;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit hold_low = 1'b0;

  always #5 clk = ~clk;

  glitch_sequencer #(
    .SETTLE_CYCLES (SET),
    .TIMEOUT_CYCLES(TMO),
    .DELAY_W       (16),
    .WIDTH_W       (8)
  ) dut (
    .clkin_i      (clk),
    .rst_i        (rst),
    .start_i      (start),
    .cfg_phase_i  (cfg_phase),
    .cfg_delay_i  (cfg_delay),
    .cfg_width_i  (cfg_width),
    .trigger_i    (trigger),
    .phase_ready_i(phase_ready),
    .phase_o      (phase),
    .glitch_en_o  (glitch_en),
    .busy_o       (busy),
    .done_o       (done),
    .timeout_o    (timeout)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Wrapper stand-in: one offset step every three cycles, ready high only between steps.
  int cur_off = 0;
  int step_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      cur_off = 0;
      step_cnt = 0;
      phase_ready = 1'b1;
    end else if (hold_low) begin
      phase_ready = 1'b0;
    end else if (cur_off != int'(phase)) begin
      if (step_cnt == 2) begin
        cur_off = cur_off + ((int'(phase) > cur_off) ? 1 : -1);
        step_cnt = 0;
        phase_ready = 1'b1;
      end else begin
        step_cnt++;
        phase_ready = 1'b0;
      end
    end else begin
      phase_ready = 1'b1;
    end
  end

  // Model: settle by counting consecutive ready samples, then place the glitch window
  // and done pulse at absolute edge numbers relative to the trigger edge.
  int stage = 0, run = 0, t_entry = 0, tt = 0, m_d = 0, m_w = 0, end_edge = 0;
  logic [7:0] e_phase = '0;
  bit e_glitch = 0, e_busy = 0, e_done = 0, e_timeout = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      stage = 0;
      e_phase = '0;
      e_glitch = 0;
      e_busy = 0;
      e_done = 0;
      e_timeout = 0;
    end else begin
      e_done = 0;
      e_glitch = 0;
      case (stage)
        0: if (start) begin
          e_phase = cfg_phase;
          m_d = int'(cfg_delay);
          m_w = int'(cfg_width);
          e_timeout = 0;
          e_busy = 1;
          run = 0;
          t_entry = cyc;
          stage = 1;
        end
        1: begin
          run = phase_ready ? run + 1 : 0;
          if (run == SET) stage = 2;
          else if (cyc - t_entry == TMO) begin
            e_done = 1;
            e_timeout = 1;
            end_edge = cyc + 1;
            stage = 4;
          end
        end
        2: if (trigger) begin
          tt = cyc;
          end_edge = tt + m_d + m_w + 2;
          stage = 3;
        end
        3: begin
          e_glitch = (cyc >= tt + m_d + 1) && (cyc <= tt + m_d + m_w);
          e_done = (cyc == tt + m_d + m_w + 1);
          if (cyc == end_edge) begin
            stage = 0;
            e_busy = 0;
          end
        end
        4: if (cyc == end_edge) begin
          stage = 0;
          e_busy = 0;
        end
        default: stage = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("phase", int'(phase), int'(e_phase));
      chk("glitch_en", int'(glitch_en), int'(e_glitch));
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("timeout", int'(timeout), int'(e_timeout));
    end
  end

  task automatic do_start(input int p, input int d, input int w);
    repeat (2) @(negedge clk);
    start = 1'b1;
    cfg_phase = 8'(p);
    cfg_delay = 16'(d);
    cfg_width = 8'(w);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_trigger();
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_phase", int'(phase), 0);
    chk("rst_glitch", int'(glitch_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_timeout", int'(timeout), 0);

    // Normal run: phase 5, delay 3, width 2
    do_start(5, 3, 2);
    chk("norm_busy_start", int'(busy), 1);
    chk("norm_phase", int'(phase), 5);
    repeat (40) @(negedge clk);
    pulse_trigger();
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("norm_glitch", int'(glitch_en), int'(k == 4 || k == 5));
      chk("norm_done", int'(done), int'(k == 6));
      chk("norm_busy", int'(busy), int'(k <= 6));
      if (k == 6) chk("norm_timeout", int'(timeout), 0);
    end

    // Same phase with trigger already high: ARM at start+8, glitch at start+10
    trigger = 1'b1;
    do_start(5, 0, 1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk("same_glitch", int'(glitch_en), int'(k == 10));
      chk("same_done", int'(done), int'(k == 11));
    end
    trigger = 1'b0;

    // Zero width
    do_start(5, 2, 0);
    repeat (20) @(negedge clk);
    pulse_trigger();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("w0_glitch", int'(glitch_en), 0);
      chk("w0_done", int'(done), int'(k == 3));
    end

    // Start during DELAY must be ignored
    do_start(5, 3, 2);
    repeat (20) @(negedge clk);
    pulse_trigger();
    @(negedge clk);
    start = 1'b1;
    cfg_phase = 8'd200;
    cfg_delay = 16'd0;
    cfg_width = 8'd9;
    @(negedge clk);
    start = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      chk("ign_phase", int'(phase), 5);
      chk("ign_glitch", int'(glitch_en), int'(k == 4 || k == 5));
      chk("ign_done", int'(done), int'(k == 6));
    end

    // Reset in glitch cycle 10 of a width-100 window
    do_start(5, 1, 100);
    repeat (20) @(negedge clk);
    pulse_trigger();
    repeat (11) @(negedge clk);
    chk("rg_glitch_c10", int'(glitch_en), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rg_glitch", int'(glitch_en), 0);
    chk("rg_busy", int'(busy), 0);
    chk("rg_phase", int'(phase), 0);
    chk("rg_done", int'(done), 0);
    repeat (5) @(negedge clk);

    // Settle timeout with ready held low
    hold_low = 1'b1;
    do_start(7, 0, 1);
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      if (k == 99) chk("tmo_done_early", int'(done), 0);
      if (k == 100) begin
        chk("tmo_done", int'(done), 1);
        chk("tmo_flag", int'(timeout), 1);
      end
      if (k == 101) chk("tmo_busy_clear", int'(busy), 0);
    end
    hold_low = 1'b0;
    repeat (5) @(negedge clk);
    chk("tmo_hold", int'(timeout), 1);

    do_start(7, 1, 3);
    chk("tmo_clear", int'(timeout), 0);
    repeat (40) @(negedge clk);
    pulse_trigger();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("last_glitch", int'(glitch_en), int'(k >= 2 && k <= 4));
      chk("last_done", int'(done), int'(k == 5));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
